// File: rtl/div_pkg.sv
// Shared constants for the clock-divide scheduler: FSM state codes and
// default sizing/limits used by div_sched and div_core.
package div_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

  localparam int MIN_DIV   = 2;
  localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/div_core.sv
// Phase counter with wrap detect and registered div_en/div_clk decode.
// The ratio register lives here and is replaced via load/load_div.
module div_core #(
  parameter int CNT_W       = div_pkg::CNT_W_DEF,
  parameter int DIV_DEFAULT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic [CNT_W-1:0] cur_div,
  output logic [CNT_W-1:0] po_cnt,
  output logic             div_en,
  output logic             div_clk,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_DEFAULT);

  logic             running;
  logic [CNT_W-1:0] div_next;
  logic [CNT_W-1:0] cnt_next;
  logic             en_next;
  logic             clk_next;

  assign wrap = running && (po_cnt == cur_div - ONE);

  // A new ratio always starts a fresh period at phase 0, so the counter can
  // never sit above the new N-1.
  always_comb begin
    div_next = load ? load_div : cur_div;
    if (!run || !running || load || wrap) begin
      cnt_next = '0;
    end else begin
      cnt_next = po_cnt + ONE;
    end
    en_next  = run && (cnt_next == div_next - ONE);
    clk_next = run && (cnt_next < (div_next >> 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running <= 1'b0;
      cur_div <= DIV_INIT;
      po_cnt  <= '0;
      div_en  <= 1'b0;
      div_clk <= 1'b0;
    end else begin
      running <= run;
      cur_div <= div_next;
      po_cnt  <= cnt_next;
      div_en  <= en_next;
      div_clk <= clk_next;
    end
  end

endmodule

// File: rtl/div_sched.sv
// Divider run-time controller: FSM, pending-ratio register and the
// req/ack/err handshake; ratio changes land only on period boundaries.
module div_sched #(
  parameter int CNT_W       = div_pkg::CNT_W_DEF,
  parameter int DIV_DEFAULT = 4,
  parameter int MIN_DIV     = div_pkg::MIN_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_req,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div,
  output logic [CNT_W-1:0] po_cnt,
  output logic             div_en,
  output logic             div_clk
);

  import div_pkg::*;

  localparam logic [CNT_W-1:0] MIN_V    = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_DEFAULT);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] pend_next;
  logic             req_ok;
  logic             req_bad;
  logic             run;
  logic             load;
  logic [CNT_W-1:0] load_div;
  logic             ack_next;
  logic             wrap;

  assign req_ok  = cfg_req && (cfg_div >= MIN_V);
  assign req_bad = cfg_req && (cfg_div < MIN_V);

  always_comb begin
    state_next = state;
    pend_next  = pend_div;
    run        = 1'b0;
    load       = 1'b0;
    load_div   = cur_div;
    ack_next   = 1'b0;
    case (state)
      IDLE: begin
        if (req_ok) begin
          load     = 1'b1;
          load_div = cfg_div;
          ack_next = 1'b1;
        end
        if (en) begin
          state_next = RUN;
          run        = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_next = IDLE;
          if (req_ok) begin
            load     = 1'b1;
            load_div = cfg_div;
            ack_next = 1'b1;
          end
        end else begin
          run = 1'b1;
          if (req_ok) begin
            pend_next  = cfg_div;
            state_next = PEND;
          end
        end
      end
      PEND: begin
        if (!en) begin
          // Stopping flushes the pending ratio; a same-cycle request supersedes it.
          state_next = IDLE;
          load       = 1'b1;
          load_div   = req_ok ? cfg_div : pend_div;
          ack_next   = 1'b1;
        end else begin
          run = 1'b1;
          if (wrap) begin
            load       = 1'b1;
            load_div   = pend_div;
            ack_next   = 1'b1;
            state_next = RUN;
          end
          // A request landing on the wrap cycle waits for the following wrap.
          if (req_ok) begin
            pend_next  = cfg_div;
            state_next = PEND;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pend_div <= DIV_INIT;
      busy     <= 1'b0;
      cfg_ack  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_next;
      pend_div <= pend_next;
      busy     <= (state_next == PEND);
      cfg_ack  <= ack_next;
      cfg_err  <= req_bad;
    end
  end

  div_core #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .load     (load),
    .load_div (load_div),
    .cur_div  (cur_div),
    .po_cnt   (po_cnt),
    .div_en   (div_en),
    .div_clk  (div_clk),
    .wrap     (wrap)
  );

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: reset, free run, ratio changes in each state,
// rejected requests, stop-while-pending and asynchronous reset.
module tb_div_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       cfg_req = 1'b0;
  logic [3:0] cfg_div = 4'd0;
  logic       cfg_ack;
  logic       cfg_err;
  logic       busy;
  logic [3:0] cur_div;
  logic [3:0] po_cnt;
  logic       div_en;
  logic       div_clk;

  int n_checks = 0;
  int n_fails = 0;

  always #5 clk = ~clk;

  div_sched dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .cfg_req (cfg_req),
    .cfg_div (cfg_div),
    .cfg_ack (cfg_ack),
    .cfg_err (cfg_err),
    .busy    (busy),
    .cur_div (cur_div),
    .po_cnt  (po_cnt),
    .div_en  (div_en),
    .div_clk (div_clk)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; cfg_req = 1'b0;
    step(); step();
    n_checks++;
    if ({cur_div, po_cnt, div_en, div_clk, cfg_ack, cfg_err, busy} !== {4'd4, 4'd0, 5'b0}) begin
      n_fails++;
      $display("FAIL reset_values got cur=%0d po=%0d en=%b clk=%b ack=%b err=%b busy=%b want cur=4 po=0 rest=0",
               cur_div, po_cnt, div_en, div_clk, cfg_ack, cfg_err, busy);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if ({po_cnt, div_en, div_clk} !== {4'd0, 2'b0}) begin
      n_fails++;
      $display("FAIL idle_hold got po=%0d en=%b clk=%b want po=0 en=0 clk=0", po_cnt, div_en, div_clk);
    end
  endtask

  task automatic test_free_run();
    int ep[8];
    logic [7:0] een;
    logic [7:0] eclk;
    ep = '{0, 1, 2, 3, 0, 1, 2, 3};
    een  = 8'b1000_1000;   // bit i = cycle i
    eclk = 8'b0011_0011;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (po_cnt !== 4'(ep[i]) || div_en !== een[i] || div_clk !== eclk[i] || cur_div !== 4'd4) begin
        n_fails++;
        $display("FAIL free_run[%0d] got cur=%0d po=%0d en=%b clk=%b want cur=4 po=%0d en=%b clk=%b",
                 i, cur_div, po_cnt, div_en, div_clk, ep[i], een[i], eclk[i]);
      end
    end
    en = 1'b0;
    step();
    n_checks++;
    if ({po_cnt, div_en, div_clk} !== {4'd0, 2'b0}) begin
      n_fails++;
      $display("FAIL stop_to_idle got po=%0d en=%b clk=%b want po=0 en=0 clk=0", po_cnt, div_en, div_clk);
    end
  endtask

  task automatic test_idle_cfg();
    logic [5:0] eclk;
    eclk = 6'b000_111;
    cfg_req = 1'b1; cfg_div = 4'd6;
    step();
    cfg_req = 1'b0;
    n_checks++;
    if (cur_div !== 4'd6 || cfg_ack !== 1'b1 || busy !== 1'b0 || po_cnt !== 4'd0) begin
      n_fails++;
      $display("FAIL idle_apply got cur=%0d ack=%b busy=%b po=%0d want cur=6 ack=1 busy=0 po=0",
               cur_div, cfg_ack, busy, po_cnt);
    end
    step();
    n_checks++;
    if (cfg_ack !== 1'b0 || cur_div !== 4'd6) begin
      n_fails++;
      $display("FAIL idle_ack_single got ack=%b cur=%0d want ack=0 cur=6", cfg_ack, cur_div);
    end
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (po_cnt !== 4'(i) || div_clk !== eclk[i] || div_en !== (i == 5)) begin
        n_fails++;
        $display("FAIL n6_run[%0d] got po=%0d clk=%b en=%b want po=%0d clk=%b en=%b",
                 i, po_cnt, div_clk, div_en, i, eclk[i], (i == 5));
      end
    end
    // en low together with a request: immediate apply on the way to IDLE
    en = 1'b0; cfg_req = 1'b1; cfg_div = 4'd4;
    step();
    cfg_req = 1'b0;
    n_checks++;
    if (cur_div !== 4'd4 || cfg_ack !== 1'b1 || po_cnt !== 4'd0 || div_clk !== 1'b0 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL stop_with_req got cur=%0d ack=%b po=%0d clk=%b busy=%b want cur=4 ack=1 po=0 clk=0 busy=0",
               cur_div, cfg_ack, po_cnt, div_clk, busy);
    end
  endtask

  task automatic test_run_change();
    int ep[6];
    int ec[6];
    logic [5:0] een;
    logic [5:0] eclk;
    logic [5:0] ebusy;
    logic [5:0] eack;
    ep = '{2, 3, 0, 1, 2, 0};
    ec = '{4, 4, 3, 3, 3, 3};
    een   = 6'b010_010;
    eclk  = 6'b100_100;
    ebusy = 6'b000_011;
    eack  = 6'b000_100;
    en = 1'b1;
    step(); step();
    n_checks++;
    if (po_cnt !== 4'd1) begin
      n_fails++;
      $display("FAIL run_change_setup got po=%0d want po=1", po_cnt);
    end
    cfg_req = 1'b1; cfg_div = 4'd3;
    for (int i = 0; i < 6; i++) begin
      step();
      cfg_req = 1'b0;
      n_checks++;
      if (po_cnt !== 4'(ep[i]) || cur_div !== 4'(ec[i]) || div_en !== een[i] || div_clk !== eclk[i] ||
          busy !== ebusy[i] || cfg_ack !== eack[i]) begin
        n_fails++;
        $display("FAIL run_change[%0d] got cur=%0d po=%0d en=%b clk=%b busy=%b ack=%b want cur=%0d po=%0d en=%b clk=%b busy=%b ack=%b",
                 i, cur_div, po_cnt, div_en, div_clk, busy, cfg_ack,
                 ec[i], ep[i], een[i], eclk[i], ebusy[i], eack[i]);
      end
    end
    en = 1'b0; cfg_req = 1'b1; cfg_div = 4'd4;
    step();
    cfg_req = 1'b0;
    n_checks++;
    if (cur_div !== 4'd4 || cfg_ack !== 1'b1) begin
      n_fails++;
      $display("FAIL restore_n4 got cur=%0d ack=%b want cur=4 ack=1", cur_div, cfg_ack);
    end
  endtask

  task automatic test_wrap_req();
    int ep[12];
    int ec[12];
    logic [11:0] ebusy;
    logic [11:0] eack;
    logic [11:0] een;
    logic [11:0] eclk;
    ep = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 0};
    ec = '{4, 4, 4, 4, 7, 7, 7, 7, 7, 7, 7, 7};
    ebusy = 12'b0000_0000_1111;
    eack  = 12'b0000_0001_0000;
    een   = 12'b0100_0000_1000;
    eclk  = 12'b1000_0111_0011;
    en = 1'b1;
    step(); step(); step(); step();
    n_checks++;
    if (po_cnt !== 4'd3 || div_en !== 1'b1) begin
      n_fails++;
      $display("FAIL wrap_req_setup got po=%0d en=%b want po=3 en=1", po_cnt, div_en);
    end
    cfg_req = 1'b1; cfg_div = 4'd5;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if (po_cnt !== 4'(ep[i]) || cur_div !== 4'(ec[i]) || busy !== ebusy[i] || cfg_ack !== eack[i] ||
          div_en !== een[i] || div_clk !== eclk[i]) begin
        n_fails++;
        $display("FAIL wrap_req[%0d] got cur=%0d po=%0d busy=%b ack=%b en=%b clk=%b want cur=%0d po=%0d busy=%b ack=%b en=%b clk=%b",
                 i, cur_div, po_cnt, busy, cfg_ack, div_en, div_clk,
                 ec[i], ep[i], ebusy[i], eack[i], een[i], eclk[i]);
      end
      cfg_req = (i == 1);
      if (i == 1) cfg_div = 4'd7;
    end
  endtask

  task automatic test_cfg_err();
    cfg_req = 1'b1; cfg_div = 4'd1;
    step();
    n_checks++;
    if (cfg_err !== 1'b1 || po_cnt !== 4'd1 || cur_div !== 4'd7 || busy !== 1'b0 || cfg_ack !== 1'b0) begin
      n_fails++;
      $display("FAIL err_div1 got err=%b po=%0d cur=%0d busy=%b ack=%b want err=1 po=1 cur=7 busy=0 ack=0",
               cfg_err, po_cnt, cur_div, busy, cfg_ack);
    end
    cfg_div = 4'd0;
    step();
    cfg_req = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b1 || po_cnt !== 4'd2 || cur_div !== 4'd7 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL err_div0 got err=%b po=%0d cur=%0d busy=%b want err=1 po=2 cur=7 busy=0",
               cfg_err, po_cnt, cur_div, busy);
    end
    step();
    n_checks++;
    if (cfg_err !== 1'b0 || po_cnt !== 4'd3) begin
      n_fails++;
      $display("FAIL err_clear got err=%b po=%0d want err=0 po=3", cfg_err, po_cnt);
    end
  endtask

  task automatic test_en_drop_pend();
    cfg_req = 1'b1; cfg_div = 4'd8;
    step();
    n_checks++;
    if (busy !== 1'b1 || po_cnt !== 4'd4 || cur_div !== 4'd7) begin
      n_fails++;
      $display("FAIL pend8 got busy=%b po=%0d cur=%0d want busy=1 po=4 cur=7", busy, po_cnt, cur_div);
    end
    cfg_div = 4'd1;
    step();
    cfg_req = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b1 || po_cnt !== 4'd5 || cur_div !== 4'd7) begin
      n_fails++;
      $display("FAIL err_in_pend got err=%b busy=%b po=%0d cur=%0d want err=1 busy=1 po=5 cur=7",
               cfg_err, busy, po_cnt, cur_div);
    end
    en = 1'b0;
    step();
    n_checks++;
    if ({cur_div, po_cnt, cfg_ack, busy, div_clk, div_en, cfg_err} !== {4'd8, 4'd0, 5'b10000}) begin
      n_fails++;
      $display("FAIL drop_pend got cur=%0d po=%0d ack=%b busy=%b clk=%b en=%b err=%b want cur=8 po=0 ack=1 busy=0 clk=0 en=0 err=0",
               cur_div, po_cnt, cfg_ack, busy, div_clk, div_en, cfg_err);
    end
    step();
    n_checks++;
    if (cfg_ack !== 1'b0 || po_cnt !== 4'd0 || cur_div !== 4'd8) begin
      n_fails++;
      $display("FAIL drop_pend_after got ack=%b po=%0d cur=%0d want ack=0 po=0 cur=8", cfg_ack, po_cnt, cur_div);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    step(); step();
    cfg_req = 1'b1; cfg_div = 4'd5;
    step();
    cfg_req = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || div_clk !== 1'b1 || po_cnt !== 4'd2) begin
      n_fails++;
      $display("FAIL areset_setup got busy=%b clk=%b po=%0d want busy=1 clk=1 po=2", busy, div_clk, po_cnt);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({cur_div, po_cnt, div_en, div_clk, cfg_ack, cfg_err, busy} !== {4'd4, 4'd0, 5'b0}) begin
      n_fails++;
      $display("FAIL areset_immediate got cur=%0d po=%0d en=%b clk=%b ack=%b err=%b busy=%b want cur=4 po=0 rest=0",
               cur_div, po_cnt, div_en, div_clk, cfg_ack, cfg_err, busy);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (po_cnt !== 4'(i % 4) || cur_div !== 4'd4 || cfg_ack !== 1'b0 || busy !== 1'b0) begin
        n_fails++;
        $display("FAIL post_reset[%0d] got po=%0d cur=%0d ack=%b busy=%b want po=%0d cur=4 ack=0 busy=0",
                 i, po_cnt, cur_div, cfg_ack, busy, i % 4);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_idle_cfg();
    test_run_change();
    test_wrap_req();
    test_cfg_err();
    test_en_drop_pend();
    test_async_reset();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
